// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - turns absolute/manual duty requests into spaced pwm step strobes
// Optional SOFT_START_EN: ramp duty to 0 and back to INITIAL_DUTY after reset release.
module pwm_duty_sequencer #(
  parameter int MAX_DUTY     = 10,
  parameter int INITIAL_DUTY = 5,
  parameter int STEP_GAP     = 4,
  parameter int DW           = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          target_valid,
  output logic          target_ready,
  input  logic [DW-1:0] target_duty,
  input  logic          manual_inc,
  input  logic          manual_dec,
  output logic          increase_duty_out,
  output logic          decrease_duty_out,
  output logic [DW-1:0] duty_cur,
  output logic          busy,
  output logic          target_err
);

  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DUTY);
  localparam logic [DW-1:0] INIT_D   = DW'(INITIAL_DUTY);
  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [7:0]    GAP_LOAD = 8'(STEP_GAP - 2);

  typedef enum logic [1:0] {IDLE, STEP, GAP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] target_q, target_n, duty_n;
  logic [7:0]    gap_cnt, gap_n;
  logic          inc_n, dec_n, err_n, go_step;
`ifdef SOFT_START_EN
  logic          ramp_up, ramp_up_n;
`endif

  always_comb begin
    state_n  = state;
    target_n = target_q;
    duty_n   = duty_cur;
    gap_n    = gap_cnt;
    inc_n    = 1'b0;
    dec_n    = 1'b0;
    err_n    = 1'b0;
    go_step  = 1'b0;
`ifdef SOFT_START_EN
    ramp_up_n = ramp_up;
`endif
    case (state)
      IDLE: begin
        if (target_valid && target_ready) begin
          err_n    = (target_duty > MAX_D);
          target_n = err_n ? MAX_D : target_duty;
          go_step  = (target_n != duty_cur);
        end else if (manual_inc && !manual_dec && duty_cur < MAX_D) begin
          target_n = duty_cur + ONE;
          go_step  = 1'b1;
        end else if (manual_dec && !manual_inc && duty_cur != '0) begin
          target_n = duty_cur - ONE;
          go_step  = 1'b1;
        end
      end
      STEP: begin
        if (duty_cur == target_q) begin
`ifdef SOFT_START_EN
          // Bottom of the soft-start descent: retarget to the initial duty and keep going.
          if (ramp_up && target_q != INIT_D) begin
            target_n  = INIT_D;
            ramp_up_n = 1'b0;
            state_n   = GAP;
            gap_n     = GAP_LOAD;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end else begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          if (target_q != duty_cur) go_step = 1'b1;
          else                      state_n = IDLE;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Strobe and shadow update are registered together so they appear in the STEP cycle.
    if (go_step) begin
      state_n = STEP;
      if (duty_cur < target_n) begin
        inc_n  = 1'b1;
        duty_n = duty_cur + ONE;
      end else begin
        dec_n  = 1'b1;
        duty_n = duty_cur - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_cur          <= INIT_D;
      gap_cnt           <= 8'd0;
      increase_duty_out <= 1'b0;
      decrease_duty_out <= 1'b0;
      target_err        <= 1'b0;
`ifdef SOFT_START_EN
      state             <= GAP;
      target_q          <= '0;
      ramp_up           <= 1'b1;
      busy              <= 1'b1;
      target_ready      <= 1'b0;
`else
      state             <= IDLE;
      target_q          <= INIT_D;
      busy              <= 1'b0;
      target_ready      <= 1'b1;
`endif
    end else begin
      state             <= state_n;
      target_q          <= target_n;
      duty_cur          <= duty_n;
      gap_cnt           <= gap_n;
      increase_duty_out <= inc_n;
      decrease_duty_out <= dec_n;
      target_err        <= err_n;
      busy              <= (state_n != IDLE);
      target_ready      <= (state_n == IDLE);
`ifdef SOFT_START_EN
      ramp_up           <= ramp_up_n;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb/tb_pwm_duty_sequencer.sv - scoreboard bench for pwm_duty_sequencer
// Driver schedules expected strobes from duty arithmetic; monitor pops and compares.
module tb_pwm_duty_sequencer;

  localparam int MAXD = 10;
  localparam int INIT = 5;
  localparam int GAPC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       target_valid = 1'b0;
  logic       target_ready;
  logic [3:0] target_duty = 4'd0;
  logic       manual_inc = 1'b0;
  logic       manual_dec = 1'b0;
  logic       increase_duty_out;
  logic       decrease_duty_out;
  logic [3:0] duty_cur;
  logic       busy;
  logic       target_err;

  pwm_duty_sequencer #(.MAX_DUTY(MAXD), .INITIAL_DUTY(INIT), .STEP_GAP(GAPC), .DW(4)) dut (
    .clk(clk), .reset_n(reset_n), .target_valid(target_valid), .target_ready(target_ready),
    .target_duty(target_duty), .manual_inc(manual_inc), .manual_dec(manual_dec),
    .increase_duty_out(increase_duty_out), .decrease_duty_out(decrease_duty_out),
    .duty_cur(duty_cur), .busy(busy), .target_err(target_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; bit up; int d; } ev_t;
  ev_t sq[$];
  int  eq[$];
  int  checks = 0;
  int  failures = 0;
  int  mduty = INIT;
  int  busy_until = 0;
  bit  in_reset = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference: |target - duty| strobes, first one cycle after accept, then every GAPC.
  task automatic model_apply(input bit tv, input int td, input bit mi, input bit md);
    int k, t, n;
    bit up;
    k = cyc;
    if (in_reset || k < busy_until) return;
    if (tv) begin
      t = (td > MAXD) ? MAXD : td;
      if (td > MAXD) eq.push_back(k + 1);
    end else if (mi && !md && mduty < MAXD) t = mduty + 1;
    else if (md && !mi && mduty > 0) t = mduty - 1;
    else return;
    if (t == mduty) return;
    up = (t > mduty);
    n = up ? t - mduty : mduty - t;
    for (int i = 0; i < n; i++)
      sq.push_back('{k + 1 + i * GAPC, up, up ? mduty + i + 1 : mduty - i - 1});
    busy_until = k + 1 + (n - 1) * GAPC + 1;
    mduty = t;
  endtask

  task automatic step(input bit tv, input int td, input bit mi, input bit md);
    @(negedge clk);
    #1;
    target_valid = tv;
    target_duty  = 4'(td);
    manual_inc   = mi;
    manual_dec   = md;
    model_apply(tv, td, mi, md);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && cyc < busy_until + 1; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  // Monitor: samples on the falling edge, before the driver touches anything.
  always @(negedge clk) begin
    if (!in_reset) begin
      check("ready", int'(target_ready), int'(cyc >= busy_until));
      check("busy", int'(busy), int'(cyc < busy_until));
      if (cyc >= busy_until) check("idle_duty", int'(duty_cur), mduty);
      if (increase_duty_out && decrease_duty_out) check("both_strobes", 1, 0);
      if (increase_duty_out || decrease_duty_out) begin
        if (sq.size() == 0 || sq[0].c != cyc) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          check("strobe_dir_inc", int'(increase_duty_out), int'(sq[0].up));
          check("strobe_duty", int'(duty_cur), sq[0].d);
          void'(sq.pop_front());
        end
      end
      while (sq.size() > 0 && sq[0].c <= cyc) begin
        check("missed_strobe", sq[0].c, -1);
        void'(sq.pop_front());
      end
      if (target_err) begin
        if (eq.size() == 0 || eq[0] != cyc) check("unexpected_err", 1, 0);
        else void'(eq.pop_front());
      end
      while (eq.size() > 0 && eq[0] <= cyc) begin
        check("missed_err", eq[0], -1);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_duty", int'(duty_cur), INIT);
    check("rst_ready", int'(target_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_inc", int'(increase_duty_out), 0);
    check("rst_dec", int'(decrease_duty_out), 0);
    check("rst_err", int'(target_err), 0);
    reset_n  = 1'b1;
    in_reset = 1'b0;

    step(1, 8, 0, 0);          // ramp 5 -> 8
    wait_idle();
    step(1, 9, 0, 0);
    wait_idle();
    step(1, 15, 0, 0);         // clamped to 10
    wait_idle();
    step(0, 0, 1, 0);          // inc at max: ignored
    wait_idle();
    step(0, 0, 1, 1);          // both: ignored
    wait_idle();
    step(0, 0, 0, 1);          // 10 -> 9
    wait_idle();
    step(1, 5, 0, 0);
    wait_idle();
    step(1, 2, 1, 0);          // target beats manual
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);          // dropped while busy
    wait_idle();
    check("dir_final_duty", mduty, 2);

    step(1, 8, 0, 0);          // reset after the second strobe
    repeat (6) step(0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    sq.delete();
    eq.delete();
    #1;
    check("mid_rst_inc", int'(increase_duty_out), 0);
    check("mid_rst_dec", int'(decrease_duty_out), 0);
    check("mid_rst_duty", int'(duty_cur), INIT);
    check("mid_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #1;
    reset_n    = 1'b1;
    mduty      = INIT;
    busy_until = 0;
    in_reset   = 1'b0;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 15),
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
    wait_idle();
    check("drain_strobes", sq.size(), 0);
    check("drain_errs", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
